div8: RTL and testbench
=======================

DIV8 -- requirements
Module: div8

Interface
REQ-001 Parameters: none; widths fixed (divisor 8 bits, dividend 16 bits, 16 iterations).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 sig  input  1  reset: synchronous, active-high; clears all state when high at a rising edge.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 ina  input  16  dividend; captured on accepted start.
REQ-006 inb  input  8  divisor; captured on accepted start.
REQ-007 out  output  16  quotient, registered.
REQ-008 rem  output  8  remainder, registered.
REQ-009 busy  output  1  high whenever state != IDLE.
REQ-010 done  output  1  single-cycle pulse; result valid.
REQ-011 dz  output  1  divide-by-zero flag; valid with done, held with the result.

Function
REQ-012 FSM states: IDLE, RUN, DONE. Transitions: IDLE->RUN on start with inb!=0; IDLE->DONE on start with inb==0; RUN->DONE after the 16th iteration; DONE->IDLE unconditionally.
REQ-013 Accepted start (edge N): latch ina into quotient/shift register, latch inb into divisor register, clear the 9-bit partial remainder, clear the iteration counter, clear dz.
REQ-014 Each RUN edge performs one restoring step: P = {partial[7:0], q[15]}; q shifts left; if P >= divisor, partial = P - divisor and q[0] = 1; else partial = P and q[0] = 0.
REQ-015 The partial remainder is 9 bits wide so the compare never overflows; the subtraction result always fits in 8 bits.
REQ-016 Latency: iterations occur at edges N+1..N+16; at edge N+16 out, rem and done are registered and state enters DONE; done is high for exactly the one cycle after edge N+16.
REQ-017 Divide-by-zero: at edge N, state -> DONE, out = 16'hFFFF, rem = ina[7:0], dz = 1, done is high in the cycle after edge N.
REQ-018 out, rem and dz hold their values from done until the next accepted start; they do not change during a later RUN until that RUN's done edge.
REQ-019 start while busy (RUN or DONE) is ignored; no queueing; a start held high across DONE->IDLE is accepted at the first IDLE edge.
REQ-020 ina and inb changing after capture have no effect on the operation in progress.
REQ-021 Result identity: ina == out*inb + rem with rem < inb for all inb != 0.

Reset
REQ-022 sig high at an edge forces state IDLE, out = 0, rem = 0, busy = 0, done = 0, dz = 0, and clears the counter and internal registers.
REQ-023 Reset during RUN or DONE aborts the operation; no done pulse is produced for it.
REQ-024 sig has priority over start at the same edge.

Structure
REQ-025 Shared package div8_pkg holds the state enum (IDLE, RUN, DONE), DIVISOR_W = 8, DIVIDEND_W = 16, ITER = 16, and DZ_QUOT = 16'hFFFF.
REQ-026 One combinational sub-module div8_step (inputs: partial, q msb, divisor; outputs: next partial, quotient bit) implements REQ-014.
REQ-027 div8 contains the FSM, counter, operand registers and output registers; the counter is 5 bits wide.

Verification
REQ-028 start with ina=1000, inb=7 -> done exactly 17 cycles after the start edge, out=142, rem=6, dz=0.
REQ-029 ina=16'hFFFF, inb=1 -> out=16'hFFFF, rem=0; then ina=16'hFF00, inb=8'hFF -> out=16'h0100, rem=0.
REQ-030 ina=16'h1234, inb=0 -> done in the cycle after start, out=16'hFFFF, rem=8'h34, dz=1, busy high for 1 cycle.
REQ-031 ina=12345, inb=100 started; ina/inb changed and start pulsed again at cycle 5 -> second start ignored, out=123, rem=45.
REQ-032 sig asserted at iteration 8 -> next cycle all outputs 0, state IDLE, no done pulse; a new start then runs normally.
REQ-033 Random sweep of 1000 operand pairs with inb!=0 -> REQ-021 holds and busy is high for 17 cycles on each operation.

Source files
------------

// File: rtl/div8_pkg.sv
// Shared types and constants for the 16/8 restoring divider.
package div8_pkg;
  localparam int DIVISOR_W  = 8;
  localparam int DIVIDEND_W = 16;
  localparam int ITER       = 16;
  localparam int CNT_W      = 5;
  localparam logic [DIVIDEND_W-1:0] DZ_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/div8_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div8_step
  import div8_pkg::*;
(
  input  logic [DIVISOR_W:0]   partial_i,
  input  logic                 q_msb_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   partial_o,
  output logic                 q_bit_o
);
  logic [DIVISOR_W:0] p;
  // partial is always < divisor, so its top bit is zero and drops out of the shift
  logic unused_partial_msb;
  assign unused_partial_msb = partial_i[DIVISOR_W];

  always_comb begin
    p = {partial_i[DIVISOR_W-1:0], q_msb_i};
    if (p >= {1'b0, divisor_i}) begin
      partial_o = p - {1'b0, divisor_i};
      q_bit_o   = 1'b1;
    end else begin
      partial_o = p;
      q_bit_o   = 1'b0;
    end
  end
endmodule

// File: rtl/div8.sv
// Sequential 16/8 divider: 16 restoring iterations, registered quotient/remainder/dz.
module div8
  import div8_pkg::*;
(
  input  logic                  clk,
  input  logic                  sig,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] ina,
  input  logic [DIVISOR_W-1:0]  inb,
  output logic [DIVIDEND_W-1:0] out,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  busy,
  output logic                  done,
  output logic                  dz
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  div_q, div_d;
  logic [DIVISOR_W:0]    part_q, part_d;
  logic [DIVIDEND_W-1:0] out_q, out_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dz_q, dz_d;
  logic                  done_q, done_d;

  logic [DIVISOR_W:0]    step_part;
  logic                  step_bit;

  div8_step u_step (
    .partial_i (part_q),
    .q_msb_i   (q_q[DIVIDEND_W-1]),
    .divisor_i (div_q),
    .partial_o (step_part),
    .q_bit_o   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    div_d   = div_q;
    part_d  = part_q;
    out_d   = out_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        q_d    = ina;
        div_d  = inb;
        part_d = '0;
        cnt_d  = '0;
        dz_d   = 1'b0;
        if (inb == '0) begin
          state_d = DONE;
          out_d   = DZ_QUOT;
          rem_d   = ina[DIVISOR_W-1:0];
          dz_d    = 1'b1;
          done_d  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        q_d    = {q_q[DIVIDEND_W-2:0], step_bit};
        part_d = step_part;
        cnt_d  = cnt_q + CNT_W'(1);
        // last iteration writes the result straight from the step outputs
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = DONE;
          out_d   = {q_q[DIVIDEND_W-2:0], step_bit};
          rem_d   = step_part[DIVISOR_W-1:0];
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sig) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      div_q   <= '0;
      part_q  <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      div_q   <= div_d;
      part_q  <= part_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign rem  = rem_q;
  assign dz   = dz_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_div8.sv
// Randomized scoreboard bench for div8: driver queues expected results, monitor checks on done.
module tb_div8;
  logic        clk = 1'b0;
  logic        sig = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ina = '0;
  logic [7:0]  inb = '0;
  logic [15:0] out;
  logic [7:0]  rem;
  logic        busy, done, dz;

  div8 dut (
    .clk(clk), .sig(sig), .start(start), .ina(ina), .inb(inb),
    .out(out), .rem(rem), .busy(busy), .done(done), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned a;
    int unsigned b;
    int unsigned q;
    int unsigned r;
    int unsigned dz;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("quotient", out, e.q);
        chk("remainder", rem, e.r);
        chk("dz_flag", dz, e.dz);
        chk("done_latency", cyc, e.done_cyc);
        if (e.b != 0) begin
          chk("identity", longint'(out) * e.b + rem, e.a);
          chk("rem_lt_div", (rem < e.b) ? 1 : 0, 1);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  // Called at a negedge while idle; returns at the negedge after the start edge.
  task automatic issue(input logic [15:0] a, input logic [7:0] b);
    exp_t e;
    ina   = a;
    inb   = b;
    start = 1'b1;
    e.a   = a;
    e.b   = b;
    e.q   = (b != 0) ? (a / b) : 16'hFFFF;
    e.r   = (b != 0) ? (a % b) : (a & 16'h00FF);
    e.dz  = (b == 0) ? 1 : 0;
    e.done_cyc = cyc + ((b != 0) ? 17 : 1);
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    wait_idle();
    issue(a, b);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("busy_len", n, (b != 0) ? 17 : 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    sig = 1'b0;
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_rem", rem, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", dz, 0);

    do_op(16'd1000, 8'd7);
    do_op(16'hFFFF, 8'd1);
    do_op(16'hFF00, 8'hFF);
    do_op(16'h1234, 8'd0);

    // restart attempt mid-run must be ignored, old result held meanwhile
    wait_idle();
    issue(16'd12345, 8'd100);
    repeat (3) @(negedge clk);
    chk("hold_out_in_run", out, 16'hFFFF);
    chk("dz_cleared_on_start", dz, 0);
    ina   = 16'd999;
    inb   = 8'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // reset part way through a run aborts it without a done pulse
    wait_idle();
    issue(16'hABCD, 8'd3);
    repeat (7) @(negedge clk);
    sig = 1'b1;
    start = 1'b1;
    exp_q.delete();
    @(negedge clk);
    sig = 1'b0;
    start = 1'b0;
    chk("abort_out", out, 0);
    chk("abort_rem", rem, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dz", dz, 0);
    repeat (20) @(negedge clk);
    do_op(16'd500, 8'd9);

    for (int i = 0; i < 1000; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      do_op(a, b);
    end

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        n++;
        @(negedge clk);
      end
      chk("pending_at_end", exp_q.size(), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
